iterative_shifter: RTL and testbench

- Multi-cycle, parametrised shift unit for the RISC-V datapath. It generalises the fixed 1-bit left shift into a variable-amount shifter.
- Supports SLL, SRL and SRA, with amounts from 0 to N-1 and STEP bits shifted per cycle.
- Uses a valid/ready handshake on both sides, so the ALU/multi-cycle control can stall on it.
- Trades area for latency versus a full barrel shifter.

---
 rtl/iterative_shifter_pkg.sv | 15 +
 rtl/iterative_shifter_shift_step.sv | 28 ++
 rtl/iterative_shifter.sv | 102 ++++++++++
 tb/tb_iterative_shifter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/iterative_shifter_pkg.sv
// Shared definitions for the iterative shifter: mode codes and FSM state encoding.
package shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// Combinational single shift stage: moves acc by k (0..STEP) positions for the given mode.
// Mode 11 is a rotate right when ITERATIVE_SHIFTER_ROTATE_EN is defined, otherwise SLL.
module shift_step
  import shifter_pkg::*;
#(
  parameter int N  = 32,
  parameter int KW = 1
) (
  input  logic [N-1:0]  acc_i,
  input  logic [KW-1:0] k_i,
  input  logic [1:0]    mode_i,
  output logic [N-1:0]  acc_o
);

  always_comb begin
    acc_o = acc_i << k_i;
    case (mode_i)
      MODE_SRL: acc_o = acc_i >> k_i;
      MODE_SRA: acc_o = $unsigned($signed(acc_i) >>> k_i);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      // k == N wraps fully: the right half becomes zero and the left half is acc itself
      MODE_ROR: acc_o = (acc_i >> k_i) | (acc_i << (N - int'(k_i)));
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle variable-amount shifter (SLL/SRL/SRA) moving up to STEP bits per cycle,
// with valid/ready on both sides. Optional ROR on mode 11 via ITERATIVE_SHIFTER_ROTATE_EN.
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int STEP = 1,
  localparam int SHW  = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  input  logic [SHW-1:0] in_shamt,
  input  logic [1:0]     in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data
);

  localparam int KW = $clog2(STEP + 1);

  state_e         state_q, state_d;
  logic [N-1:0]   acc_q, acc_d, step_acc;
  logic [SHW-1:0] rem_q, rem_d;
  logic [1:0]     mode_q, mode_d;
  logic           out_valid_q, out_valid_d;
  logic [KW-1:0]  k;

  // k = min(STEP, rem)
  assign k = (int'(rem_q) < STEP) ? KW'(rem_q) : KW'(STEP);

  shift_step #(.N(N), .KW(KW)) u_step (
    .acc_i  (acc_q),
    .k_i    (k),
    .mode_i (mode_q),
    .acc_o  (step_acc)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d  = in_data;
          rem_d  = in_shamt;
          mode_d = in_mode;
          if (in_shamt == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d = step_acc;
        rem_d = rem_q - SHW'(k);
        if (rem_d == '0) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      mode_q      <= MODE_SLL;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: STEP=1 and STEP=4 instances driven with the same requests,
// results and latencies compared against a plain-arithmetic reference model.
module tb_iterative_shifter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic        out_ready;

  logic        in_ready1, out_valid1;
  logic [31:0] out_data1;
  logic        in_ready4, out_valid4;
  logic [31:0] out_data4;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  iterative_shifter #(.N(32), .STEP(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1)
  );

  iterative_shifter #(.N(32), .STEP(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic [1:0] m);
    logic signed [31:0] s;
    s = d;
    case (m)
      2'b01: return d >> sh;
      2'b10: return s >>> sh;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      2'b11: return (d >> sh) | (d << (32 - sh));
`endif
      default: return d << sh;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] d, input int sh,
                        input logic [1:0] m, input int hold);
    logic [31:0] exp;
    int lat1, lat4, c;
    bit bad_ready, bad_stable;
    exp = ref_shift(d, sh, m);
    @(negedge clk);
    check({tag, "_ready_before"}, {30'd0, in_ready1, in_ready4}, 32'd3);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh[4:0];
    in_mode  = m;
    @(posedge clk);
    c = 1; lat1 = 0; lat4 = 0; bad_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_shamt = 5'($urandom);
    in_mode  = 2'($urandom);
    while ((lat1 == 0 || lat4 == 0) && c <= 40) begin
      if (out_valid1 && lat1 == 0) lat1 = c;
      if (out_valid4 && lat4 == 0) lat4 = c;
      if (in_ready1 || in_ready4) bad_ready = 1'b1;
      if (lat1 == 0 || lat4 == 0) begin
        @(posedge clk);
        c++;
        @(negedge clk);
      end
    end
    check({tag, "_lat1"}, 32'(lat1), 32'(sh + 1));
    check({tag, "_lat4"}, 32'(lat4), 32'((sh + 3) / 4 + 1));
    check({tag, "_data1"}, out_data1, exp);
    check({tag, "_data4"}, out_data4, exp);
    check({tag, "_busy_ready"}, 32'(bad_ready), 32'd0);
    bad_stable = 1'b0;
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid1 || !out_valid4 || out_data1 !== exp || out_data4 !== exp ||
          in_ready1 || in_ready4) bad_stable = 1'b1;
    end
    if (hold > 0) check({tag, "_hold"}, 32'(bad_stable), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_after"}, {28'd0, in_ready1, in_ready4, out_valid1, out_valid4}, 32'hC);
  endtask

  initial begin
    logic [31:0] d;
    int sh, hold;
    logic [1:0] m;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_valid", {30'd0, out_valid1, out_valid4}, 32'd0);
    check("reset_data1", out_data1, 32'd0);
    check("reset_data4", out_data4, 32'd0);
    check("reset_ready", {30'd0, in_ready1, in_ready4}, 32'd3);

    run_op("sll4", 32'h0000_0001, 4, 2'b00, 0);
    run_op("sra31", 32'h8000_0000, 31, 2'b10, 0);
    run_op("srl31", 32'h8000_0000, 31, 2'b01, 0);
    run_op("srl5", 32'hF000_0000, 5, 2'b01, 0);
    run_op("zero_hold", 32'hDEAD_BEEF, 0, 2'b00, 6);
    run_op("mode11", 32'h0000_0001, 1, 2'b11, 0);

    // abandon an operation with reset partway through shifting
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h1; in_shamt = 5'd20; in_mode = 2'b00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", {30'd0, out_valid1, out_valid4}, 32'd0);
    check("midrst_data1", out_data1, 32'd0);
    check("midrst_data4", out_data4, 32'd0);
    check("midrst_idle", {30'd0, in_ready1, in_ready4}, 32'd3);
    rst_n = 1'b1;
    run_op("after_rst", 32'h0000_0001, 20, 2'b00, 1);

    for (int i = 0; i < 12; i++) begin
      d    = $urandom;
      sh   = $urandom_range(0, 31);
      m    = 2'($urandom_range(0, 3));
      hold = $urandom_range(0, 2);
      run_op($sformatf("rnd%0d", i), d, sh, m, hold);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
